udp_out_merger_n: RTL
=====================

UDP_OUT_MERGER_N -- requirements
Module: udp_out_merger_n

Interface
REQ-001 The block SHALL have parameter NOC_DATA_W, default 512: data beat width in bits.
REQ-002 The block SHALL have parameter NOC_PADBYTES_W, default $clog2(NOC_DATA_W/8): padbytes field width.
REQ-003 The block SHALL have parameter NUM_SRCS, default 4: number of merged sources, legal range 2..16.
REQ-004 The block SHALL have parameter GRANT_Q_DEPTH, default 4: granted-message queue depth, power of 2, at least 2.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- src_meta_val  in  NUM_SRCS  per-source metadata valid
- src_meta_info  in  NUM_SRCS x udp_info  per-source metadata
- src_meta_rdy  out  NUM_SRCS  per-source metadata ready
- src_data_val  in  NUM_SRCS  per-source data valid
- src_data  in  NUM_SRCS x NOC_DATA_W  per-source data
- src_data_padbytes  in  NUM_SRCS x NOC_PADBYTES_W  per-source padbytes
- src_data_last  in  NUM_SRCS  per-source last beat
- src_data_rdy  out  NUM_SRCS  per-source data ready
- merger_dst_meta_val / merger_dst_meta_info / dst_merger_meta_rdy  out/out/in  1/udp_info/1  merged metadata
- merger_dst_data_val / _data / _data_padbytes / _data_last  out  1/NOC_DATA_W/NOC_PADBYTES_W/1  merged data
- dst_merger_data_rdy  in  1  merged data ready
- stat_msg_cnt  out  NUM_SRCS x 32  per-source completed-message count

Function
REQ-006 A round-robin arbiter SHALL choose one source among those with src_meta_val; the priority pointer SHALL move to the granted index+1 (mod NUM_SRCS) only on a meta handshake.
REQ-007 merger_dst_meta_val SHALL equal "any src_meta_val and grant queue not full"; merger_dst_meta_info SHALL be the granted source's info, with zero latency.
REQ-008 src_meta_rdy SHALL be dst_merger_meta_rdy for the granted source only, gated by queue not full, and 0 for every other source.
REQ-009 On a meta handshake the granted index SHALL be pushed into the grant queue.
REQ-010 When the queue is full, no push SHALL occur, even in a cycle that also pops.
REQ-011 While the queue is non-empty, the head index SHALL steer the data path combinationally, passing val, data, padbytes, last and rdy.
REQ-012 src_data_rdy SHALL be 0 for every non-head source.
REQ-013 A data handshake with last SHALL pop the queue; the next message's data SHALL be eligible in the following cycle, with no bubble.
REQ-014 Data for a message SHALL be eligible no earlier than the cycle after its meta handshake.
REQ-015 Meta for up to GRANT_Q_DEPTH messages SHALL be allowed to run ahead of their data.
REQ-016 Merged data order SHALL equal merged meta order.
REQ-017 Beats SHALL never interleave between messages.
REQ-018 When the queue is empty, merger_dst_data_val SHALL be 0 and all src_data_rdy SHALL be 0.
REQ-019 A single-beat message (last on the first beat) SHALL pop in the same cycle it transfers.

Reset
REQ-020 On rst the grant queue SHALL be emptied, the arbiter pointer SHALL be set to source 0, and stat_msg_cnt SHALL be zeroed.
REQ-021 During rst all rdy and val outputs SHALL be 0.
REQ-022 A message in flight when rst asserts SHALL be abandoned with no further beats; the sources are responsible for re-synchronising.

Configuration
REQ-023 With OUT_MERGER_STATS_EN defined, each stat_msg_cnt entry SHALL increment on a last-beat data handshake from that source and SHALL wrap at 2^32.
REQ-024 With OUT_MERGER_STATS_EN undefined, stat_msg_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-025 The grant queue SHALL be a sub-module merger_grant_fifo (width $clog2(NUM_SRCS), depth GRANT_Q_DEPTH), with registered read and separate full and empty flags.
REQ-026 udp_info and UDP_INFO_W SHALL come from beehive_udp_msg.
REQ-027 The stats counter width (32) SHALL be a localparam MERGER_STAT_W in beehive_udp_msg.
REQ-028 The arbiter SHALL be bsg_arb_round_robin.

Verification
REQ-029 Bench SHALL drive all 4 sources valid with 1-beat messages and rdy always 1, and check that grants cycle 0,1,2,3,0 with one message per cycle after the first.
REQ-030 Bench SHALL hold dst_merger_data_rdy=0 while 6 sources offer meta, and check that exactly 4 meta handshakes occur and then merger_dst_meta_val=0.
REQ-031 Bench SHALL send source 2 a 3-beat message and source 1 a 1-beat message, and check the data order is 2,2,2,1 with no bubble between the two messages.
REQ-032 Bench SHALL toggle source 0 src_data_val randomly mid-message while source 3 data is valid, and check that src_data_rdy[3]=0 until source 0 last.
REQ-033 Bench SHALL assert rst for 1 cycle after the second beat of a 5-beat message, and check that the queue is empty, no further beats are emitted, and the next grant is source 0.
REQ-034 With OUT_MERGER_STATS_EN, bench SHALL send 10 messages from source 1 and check stat_msg_cnt[1]=10 and the others are 0; without the macro, all counts SHALL read 0.

Source files
------------

// File: rtl/beehive_udp_msg.sv
`default_nettype none
// ============================================================================
// Module   : beehive_udp_msg (package)
// Purpose  : Shared UDP message descriptor type and merger-wide constants.
//            udp_info     - per-message metadata carried on the meta channel
//            UDP_INFO_W   - width of udp_info in bits
//            MERGER_STAT_W- width of each per-source completed-message counter
// Revision : 1.0 - initial release
// ============================================================================
package beehive_udp_msg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

  localparam int UDP_INFO_W    = $bits(udp_info);
  localparam int MERGER_STAT_W = 32;

endpackage
`default_nettype wire

// File: rtl/udp_out_merger_n_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_out_merger_n_if
// Purpose  : Bundles the N source meta/data channels, the merged destination
//            meta/data channels and the per-source message counters.
// Modports : slave  - merger side (consumes sources, drives destination)
//            master - environment side (drives sources, consumes destination)
// Revision : 1.0 - initial release
// ============================================================================
interface udp_out_merger_n_if #(
  parameter int NUM_SRCS       = 4,
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W/8)
);
  import beehive_udp_msg::*;

  logic [NUM_SRCS-1:0]                     src_meta_val;
  udp_info [NUM_SRCS-1:0]                  src_meta_info;
  logic [NUM_SRCS-1:0]                     src_meta_rdy;
  logic [NUM_SRCS-1:0]                     src_data_val;
  logic [NUM_SRCS-1:0][NOC_DATA_W-1:0]     src_data;
  logic [NUM_SRCS-1:0][NOC_PADBYTES_W-1:0] src_data_padbytes;
  logic [NUM_SRCS-1:0]                     src_data_last;
  logic [NUM_SRCS-1:0]                     src_data_rdy;

  logic                                    merger_dst_meta_val;
  udp_info                                 merger_dst_meta_info;
  logic                                    dst_merger_meta_rdy;
  logic                                    merger_dst_data_val;
  logic [NOC_DATA_W-1:0]                   merger_dst_data;
  logic [NOC_PADBYTES_W-1:0]               merger_dst_data_padbytes;
  logic                                    merger_dst_data_last;
  logic                                    dst_merger_data_rdy;

  logic [NUM_SRCS-1:0][MERGER_STAT_W-1:0]  stat_msg_cnt;

  modport slave (
    input  src_meta_val, src_meta_info, src_data_val, src_data,
           src_data_padbytes, src_data_last, dst_merger_meta_rdy, dst_merger_data_rdy,
    output src_meta_rdy, src_data_rdy, merger_dst_meta_val, merger_dst_meta_info,
           merger_dst_data_val, merger_dst_data, merger_dst_data_padbytes,
           merger_dst_data_last, stat_msg_cnt
  );

  modport master (
    output src_meta_val, src_meta_info, src_data_val, src_data,
           src_data_padbytes, src_data_last, dst_merger_meta_rdy, dst_merger_data_rdy,
    input  src_meta_rdy, src_data_rdy, merger_dst_meta_val, merger_dst_meta_info,
           merger_dst_data_val, merger_dst_data, merger_dst_data_padbytes,
           merger_dst_data_last, stat_msg_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bsg_arb_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : bsg_arb_round_robin
// Purpose  : Round-robin arbiter. Picks the first requester at or after the
//            priority pointer; the pointer advances to winner+1 (mod WIDTH)
//            only when the grant is consumed (yumi).
// Ports    : clk, rst  - clock, synchronous active-high reset (pointer -> 0)
//            reqs      - request vector
//            yumi      - grant consumed this cycle
//            v         - some request is granted
//            tag       - index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module bsg_arb_round_robin #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         reqs,
  input  logic                     yumi,
  output logic                     v,
  output logic [$clog2(WIDTH)-1:0] tag
);
  localparam int TAG_W = $clog2(WIDTH);

  logic [TAG_W-1:0] ptr;

  // (base + off) mod WIDTH, valid for non-power-of-two WIDTH too.
  function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = (32'(base) + off) % 32'(WIDTH);
    return TAG_W'(sum);
  endfunction

  always_comb begin
    v   = 1'b0;
    tag = '0;
    // Scan farthest-first so the requester nearest the pointer overwrites last.
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (reqs[wrap_idx(ptr, k)]) begin
        v   = 1'b1;
        tag = wrap_idx(ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (yumi && v)
      ptr <= wrap_idx(tag, 1);
  end

endmodule
`default_nettype wire

// File: rtl/merger_grant_fifo.sv
`default_nettype none
// ============================================================================
// Module   : merger_grant_fifo
// Purpose  : Small flop-based FIFO holding granted source indices in meta
//            order. The head entry is read straight from the storage flops so
//            a pop exposes the next entry in the following cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset (empties)
//            push, wr_data   - enqueue (ignored when full)
//            pop             - dequeue (ignored when empty)
//            rd_data         - head entry
//            full, empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module merger_grant_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/udp_out_merger_n.sv
`default_nettype none
// ============================================================================
// Module   : udp_out_merger_n
// Purpose  : Merges NUM_SRCS UDP message streams (meta + data) into one.
//            Meta is arbitrated round-robin with zero latency; each granted
//            index is queued so data follows in meta order, whole messages at
//            a time, with up to GRANT_Q_DEPTH metas running ahead of data.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - udp_out_merger_n_if.slave: source meta/data channels,
//                       merged meta/data channels, per-source msg counters
// Build    : define OUT_MERGER_STATS_EN to enable the per-source completed
//            message counters; otherwise stat_msg_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module udp_out_merger_n
  import beehive_udp_msg::*;
#(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W/8),
  parameter int NUM_SRCS       = 4,
  parameter int GRANT_Q_DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  udp_out_merger_n_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_SRCS);

  logic                      arb_v;
  logic [SRC_W-1:0]          grant_idx;
  logic [SRC_W-1:0]          head_idx;
  logic                      q_full;
  logic                      q_empty;
  logic                      meta_hs;
  logic                      pop;
  logic [NOC_DATA_W-1:0]     head_data;
  logic [NOC_PADBYTES_W-1:0] head_pad;

  bsg_arb_round_robin #(.WIDTH(NUM_SRCS)) arb (
    .clk  (clk),
    .rst  (rst),
    .reqs (bus.src_meta_val),
    .yumi (meta_hs),
    .v    (arb_v),
    .tag  (grant_idx)
  );

  merger_grant_fifo #(.WIDTH(SRC_W), .DEPTH(GRANT_Q_DEPTH)) grant_q (
    .clk     (clk),
    .rst     (rst),
    .push    (meta_hs),
    .wr_data (grant_idx),
    .pop     (pop),
    .rd_data (head_idx),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign head_data = bus.src_data[head_idx];
  assign head_pad  = bus.src_data_padbytes[head_idx];

  // Everything handshake-related is forced low during rst so nothing moves
  // in the reset cycle, including a message that was mid-transfer.
  always_comb begin
    bus.merger_dst_meta_val      = 1'b0;
    bus.merger_dst_meta_info     = bus.src_meta_info[grant_idx];
    bus.src_meta_rdy             = '0;
    bus.merger_dst_data_val      = 1'b0;
    bus.merger_dst_data          = head_data;
    bus.merger_dst_data_padbytes = head_pad;
    bus.merger_dst_data_last     = bus.src_data_last[head_idx];
    bus.src_data_rdy             = '0;
    if (!rst) begin
      // A full queue blocks new meta even when the data side pops this cycle.
      bus.merger_dst_meta_val = arb_v && !q_full;
      if (arb_v && !q_full)
        bus.src_meta_rdy[grant_idx] = bus.dst_merger_meta_rdy;
      if (!q_empty) begin
        bus.merger_dst_data_val    = bus.src_data_val[head_idx];
        bus.src_data_rdy[head_idx] = bus.dst_merger_data_rdy;
      end
    end
  end

  assign meta_hs = bus.merger_dst_meta_val && bus.dst_merger_meta_rdy;
  assign pop     = bus.merger_dst_data_val && bus.dst_merger_data_rdy && bus.merger_dst_data_last;

`ifdef OUT_MERGER_STATS_EN
  logic [NUM_SRCS-1:0][MERGER_STAT_W-1:0] msg_cnt;

  // Counts completed messages per source; wraps naturally at 2^MERGER_STAT_W.
  always_ff @(posedge clk) begin
    if (rst)
      msg_cnt <= '0;
    else if (pop)
      msg_cnt[head_idx] <= msg_cnt[head_idx] + MERGER_STAT_W'(1);
  end

  assign bus.stat_msg_cnt = msg_cnt;
`else
  assign bus.stat_msg_cnt = '0;
`endif

endmodule
`default_nettype wire
